// File: rtl/mpc_pkg.sv
// mpc_pkg: shared constants, types and helpers for mantissa_pp_compressor.
//   MW          mantissa width including hidden bit
//   TRUNC       low product bits resolved internally and reduced to sticky
//   PROD_W      full product width (2*MW)
//   ROW_W       width of the carry-save rows handed to the adder
//   NUM_PP      number of radix-4 Booth partial products
//   NUM_ROWS    partial products plus the injection/constant row
//   booth_dig_t Booth digit encoding (neg, one, two)
//   SIGN_EXT_K  sign-extension constant folded into the injection row
package mpc_pkg;

    localparam int MW       = 28;
    localparam int TRUNC    = 8;
    localparam int PROD_W   = 2 * MW;
    localparam int ROW_W    = PROD_W - TRUNC;
    localparam int NUM_PP   = (MW + 2) / 2;
    localparam int NUM_ROWS = NUM_PP + 1;

    // Booth digit: magnitude 1 (one), magnitude 2 (two), negative (neg).
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_dig_t;

    // Each partial product is emitted as {~s, p[MW:0]} so its signed value is
    // (row - 2^(MW+1)) at its weight; the -2^(MW+1+2i) terms of all rows are
    // summed here once, modulo 2^PROD_W.
    function automatic logic [PROD_W-1:0] sext_const();
        logic [PROD_W-1:0] k;
        k = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            k = k - (PROD_W'(1'b1) << (MW + 1 + 2 * i));
        end
        return k;
    endfunction

    localparam logic [PROD_W-1:0] SIGN_EXT_K = sext_const();

    // 3:2 carry-save cell, sum output.
    function automatic logic [PROD_W-1:0] csa_sum(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // 3:2 carry-save cell, carry output already shifted to its weight.
    function automatic logic [PROD_W-1:0] csa_carry(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        logic [PROD_W-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        return maj << 1;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth digit encoder and partial-product selector.
//   a_i    multiplicand (unsigned, MW bits)
//   trip_i multiplier triple {b[2i+1], b[2i], b[2i-1]}
//   pp_o   partial product {~sign, selected/inverted magnitude}, MW+2 bits
//   neg_o  digit is negative; caller injects +1 at the row LSB
module booth_pp_gen
    import mpc_pkg::*;
(
    input  logic [MW-1:0] a_i,
    input  logic [2:0]    trip_i,
    output logic [MW+1:0] pp_o,
    output logic          neg_o
);

    booth_dig_t dig;
    logic [MW:0] mag;
    logic [MW:0] sel;

    // Encode the triple; 3'b111 is treated as +0 so no negative zero row appears.
    always_comb begin
        dig = '{neg: 1'b0, one: 1'b0, two: 1'b0};
        case (trip_i)
            3'b000:  dig = '{neg: 1'b0, one: 1'b0, two: 1'b0};
            3'b001:  dig = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b010:  dig = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b011:  dig = '{neg: 1'b0, one: 1'b0, two: 1'b1};
            3'b100:  dig = '{neg: 1'b1, one: 1'b0, two: 1'b1};
            3'b101:  dig = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            3'b110:  dig = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            3'b111:  dig = '{neg: 1'b0, one: 1'b0, two: 1'b0};
            default: dig = '{neg: 1'b0, one: 1'b0, two: 1'b0};
        endcase
    end

    // Select 0, A or 2A and invert for negative digits.
    always_comb begin
        mag = '0;
        if (dig.one) begin
            mag = {1'b0, a_i};
        end else if (dig.two) begin
            mag = {a_i, 1'b0};
        end else begin
            mag = '0;
        end
        sel   = dig.neg ? ~mag : mag;
        pp_o  = {~dig.neg, sel};
        neg_o = dig.neg;
    end

endmodule

// File: rtl/mantissa_pp_compressor.sv
// mantissa_pp_compressor: Booth partial-product generation and CSA compression
// of a 28x28 unsigned mantissa product into two 48-bit carry-save rows for
// product bits [55:8]. Bits [7:0] are added exactly here; their carry is folded
// into the rows and their OR is reported as sticky, so the adder needs no cin.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a_i, b_i, ct_i)
//   out_valid/out_ready result handshake (sum_o, carry_o, ct_o, sticky_o)
//
// Build option MPC_MID_REG_EN:
//   defined   - register after the 16->4 tree, latency 2
//   undefined - single combinational path into the output register, latency 1
module mantissa_pp_compressor
    import mpc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MW-1:0]    a_i,
    input  logic [MW-1:0]    b_i,
    input  logic             ct_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] sum_o,
    output logic [ROW_W-1:0] carry_o,
    output logic             ct_o,
    output logic             sticky_o
);

    // ---------------- Stage 1: Booth rows and 16 -> 4 CSA tree ----------------
    logic [MW+2:0]       b_pad;
    logic [MW+1:0]       pp_w [NUM_PP];
    logic [NUM_PP-1:0]   neg_w;
    logic [PROD_W-1:0]   inj_row;
    logic [PROD_W-1:0]   l0 [NUM_ROWS];
    logic [PROD_W-1:0]   l1 [11];
    logic [PROD_W-1:0]   l2 [8];
    logic [PROD_W-1:0]   l3 [6];
    logic [3:0][PROD_W-1:0] l4;

    // Bit 0 is the implicit b[-1]=0; two zeros on top make the last digit non-negative.
    assign b_pad = {2'b00, b_i, 1'b0};

    genvar g;
    generate
        for (g = 0; g < NUM_PP; g++) begin : g_pp
            booth_pp_gen u_pp (
                .a_i    (a_i),
                .trip_i (b_pad[2*g+2 -: 3]),
                .pp_o   (pp_w[g]),
                .neg_o  (neg_w[g])
            );
            assign l0[g] = PROD_W'(pp_w[g]) << (2 * g);
        end
    endgenerate

    // +1 injections sit at even bits below MW+1, where the constant is zero.
    always_comb begin
        inj_row = SIGN_EXT_K;
        for (int i = 0; i < NUM_PP; i++) begin
            inj_row[2*i] = neg_w[i];
        end
    end
    assign l0[NUM_ROWS-1] = inj_row;

    // Tree shape: 16 -> 11 -> 8 -> 6 -> 4; leftover rows pass straight through.
    generate
        for (g = 0; g < 5; g++) begin : g_l1
            assign l1[2*g]   = csa_sum  (l0[3*g], l0[3*g+1], l0[3*g+2]);
            assign l1[2*g+1] = csa_carry(l0[3*g], l0[3*g+1], l0[3*g+2]);
        end
        for (g = 0; g < 3; g++) begin : g_l2
            assign l2[2*g]   = csa_sum  (l1[3*g], l1[3*g+1], l1[3*g+2]);
            assign l2[2*g+1] = csa_carry(l1[3*g], l1[3*g+1], l1[3*g+2]);
        end
        for (g = 0; g < 2; g++) begin : g_l3
            assign l3[2*g]   = csa_sum  (l2[3*g], l2[3*g+1], l2[3*g+2]);
            assign l3[2*g+1] = csa_carry(l2[3*g], l2[3*g+1], l2[3*g+2]);
        end
        for (g = 0; g < 2; g++) begin : g_l4
            assign l4[2*g]   = csa_sum  (l3[3*g], l3[3*g+1], l3[3*g+2]);
            assign l4[2*g+1] = csa_carry(l3[3*g], l3[3*g+1], l3[3*g+2]);
        end
    endgenerate
    assign l1[10] = l0[15];
    assign l2[6]  = l1[9];
    assign l2[7]  = l1[10];
    assign l3[4]  = l2[6];
    assign l3[5]  = l2[7];

    // ---------------- Pipeline control ----------------
    logic                   out_valid_q, out_valid_d;
    logic                   out_adv;
    logic [3:0][PROD_W-1:0] s2_row;
    logic                   s2_ct;
    logic                   s2_valid;

    // Output stage can take new data when empty or being drained.
    assign out_adv = ~out_valid_q | out_ready;

`ifdef MPC_MID_REG_EN
    logic                   s1_valid_q, s1_valid_d;
    logic [3:0][PROD_W-1:0] s1_row_q, s1_row_d;
    logic                   s1_ct_q, s1_ct_d;

    assign in_ready = ~s1_valid_q | out_adv;

    // Stage-1 next state: refill whenever the stage is empty or moving on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_row_d   = s1_row_q;
        s1_ct_d    = s1_ct_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_row_d = l4;
                s1_ct_d  = ct_i;
            end else begin
                s1_row_d = s1_row_q;
                s1_ct_d  = s1_ct_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage-1 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_ct_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_row_q   <= s1_row_d;
            s1_ct_q    <= s1_ct_d;
        end
    end

    assign s2_row   = s1_row_q;
    assign s2_ct    = s1_ct_q;
    assign s2_valid = s1_valid_q;
`else
    assign in_ready = out_adv;
    assign s2_row   = l4;
    assign s2_ct    = ct_i;
    assign s2_valid = in_valid;
`endif

    // ---------------- Stage 2: 4 -> 2, low-bit resolve, final 3:2 ----------------
    logic [PROD_W-1:0] t_s, t_c, x_row, y_row;
    logic [TRUNC:0]    low_sum;
    logic              c_low;
    logic [ROW_W-1:0]  hx, hy, hc, maj;
    logic [ROW_W-1:0]  sum_q, sum_d, carry_q, carry_d;
    logic              ct_q, ct_d, sticky_q, sticky_d;
    logic [ROW_W-1:0]  row_sum, row_carry;
    logic              row_sticky;

    // Reduce to two rows, add the low TRUNC bits exactly, fold their carry upward.
    always_comb begin
        t_s        = csa_sum  (s2_row[0], s2_row[1], s2_row[2]);
        t_c        = csa_carry(s2_row[0], s2_row[1], s2_row[2]);
        x_row      = csa_sum  (t_s, t_c, s2_row[3]);
        y_row      = csa_carry(t_s, t_c, s2_row[3]);
        low_sum    = {1'b0, x_row[TRUNC-1:0]} + {1'b0, y_row[TRUNC-1:0]};
        c_low      = low_sum[TRUNC];
        row_sticky = |low_sum[TRUNC-1:0];
        hx         = x_row[PROD_W-1:TRUNC];
        hy         = y_row[PROD_W-1:TRUNC];
        hc         = {{(ROW_W-1){1'b0}}, c_low};
        row_sum    = hx ^ hy ^ hc;
        maj        = (hx & hy) | (hx & hc) | (hy & hc);
        // Carry past bit 55 is dropped: the true product fits in 56 bits.
        row_carry  = maj << 1;
    end

    // Output next state: load on transfer into the stage, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ct_d        = ct_q;
        sticky_d    = sticky_q;
        if (out_adv) begin
            out_valid_d = s2_valid;
            if (s2_valid) begin
                sum_d    = row_sum;
                carry_d  = row_carry;
                ct_d     = s2_ct;
                sticky_d = row_sticky;
            end else begin
                sum_d    = sum_q;
                carry_d  = carry_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            ct_q        <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ct_q        <= ct_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_o     = sum_q;
    assign carry_o   = carry_q;
    assign ct_o      = ct_q;
    assign sticky_o  = sticky_q;

endmodule

// File: doc/mantissa_pp_compressor.md
Name: mantissa_pp_compressor

Overview:
- Upstream feeder of the 48-bit carry-select mantissa adder in the posit FMAU multiplier path.
- Takes two 28-bit unsigned mantissas (hidden bit included) and forms radix-4 Booth partial products.
- Compresses them through a pipelined CSA tree to two 48-bit carry-save rows covering product bits [55:8].
- Resolves the low 8 product bits internally, folding their carry-out into the rows and reporting their OR as sticky, so the adder needs no carry-in.

Parameters:
- MW, 28, mantissa width including hidden bit; product width is 2*MW.
- TRUNC, 8, low product bits resolved internally and reduced to sticky; row LSB index equals TRUNC.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept the operand pair this cycle
- a_i  in  MW  mantissa A, unsigned
- b_i  in  MW  mantissa B, unsigned
- ct_i  in  1  carry-kill control for the downstream adder; carried alongside the data
- out_valid  out  1  rows valid
- out_ready  in  1  downstream accepts
- sum_o  out  48  carry-save row 0, product bits [55:8]
- carry_o  out  48  carry-save row 1, product bits [55:8]
- ct_o  out  1  registered ct_i aligned with rows
- sticky_o  out  1  OR of product bits [7:0]

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n; polarity and synchronicity are fixed.
- Reset (rst_n=0 at a clk edge): all stage valids=0, out_valid=0, sum_o=0, carry_o=0, ct_o=0, sticky_o=0. in_ready=1 one cycle after reset deasserts.
- Reset mid-operation drops every in-flight operand; nothing is emitted afterwards.
- Handshake: transfer occurs when valid&ready. Data regs load only on transfer into the stage.
- in_ready = ~s1_valid | s1_advance. Stage advances when its successor is empty or advancing.
- out_valid, sum_o, carry_o, ct_o and sticky_o are held stable while out_valid&~out_ready.
- Full throughput: one op per cycle with out_ready held at 1.
- Stage 1:
  - Pad B to 30 bits with a zero at bit -1 and two zeros at the top, giving 15 Booth digits in {-2,-1,0,1,2}.
  - Each digit selects 0, ±A or ±2A; negation uses the inverted row plus a +1 injection bit, with standard sign-extension constants.
  - A 3:2 CSA tree reduces the 15 rows plus the injection row to 4 rows of 56 bits.
  - Register the 4 rows plus ct.
- Stage 2:
  - 4:2 reduce to 2 rows of 56 bits.
  - Add the low TRUNC bits exactly. sticky = OR of the 8 result bits; c8 = carry-out.
  - 3:2 reduce bits [55:8] of both rows plus c8 at bit 8.
  - Drop any carry past bit 55, since the true product is < 2^56.
  - Register sum_o, carry_o, sticky_o, ct_o.
- Latency: 2 cycles from input transfer to out_valid.
- Invariant: (sum_o+carry_o) mod 2^48 == (a_i*b_i)>>8, and sticky_o == |(a_i*b_i)[7:0].
- Operand zero: rows sum to 0 and sticky_o=0. No special casing is applied.

Optional Feature:
- MPC_MID_REG_EN defined: stage-1 register present; latency 2 (as above).
- MPC_MID_REG_EN undefined: stage-1 register removed and both stages collapse into one combinational path; latency 1; in_ready = ~out_valid | out_ready.
- Invariants and reset values are identical in both builds.

Decomposition:
- Package mpc_pkg holds:
  - MW, TRUNC, PROD_W=56, ROW_W=48, NUM_PP=15.
  - Booth digit encoding typedef (neg, one, two).
  - Sign-extension constant vector.
- Sub-module booth_pp_gen: one digit encoder and row selector, instantiated 15 times via generate.
- CSA cells are inline generate logic.

Test Plan:
- a=b=0x8000000 -> sum_o+carry_o=0x4000_0000_0000, sticky_o=0, ct_o=ct_i, out_valid 2 cycles after transfer.
- a=b=0xFFFFFFF -> sum+carry=0xFFFF_FFE0_0000, sticky_o=1 (low byte 0x01).
- a=b=0x8000001 -> sum+carry=0x4000_0010_0000, sticky_o=1. a=0x8000001, b=0x8000000 -> 0x4000_0008_0000, sticky_o=0.
- 1000 random back-to-back pairs with out_ready randomly toggled -> every result matches the reference product in order, none lost or duplicated, outputs stable during stall, in_ready=0 only when both stages are full and stalled.
- Two ops in flight, rst_n=0 for 1 cycle -> next cycle out_valid=0 and all outputs 0; no stale result appears later.
- Build with MPC_MID_REG_EN undefined, repeat the first and fourth scenarios -> latency 1, same values.
